imm_encoder: RTL and testbench

Instruction encoder: packs a format selector, register indices, function fields and a 32-bit signed immediate into a 32-bit RV32I instruction word. It performs the inverse of the core's immediate decode path. It sits in the test/boot infrastructure, feeding generated instructions to instruction memory or a program loader. It uses a valid/ready handshake with one registered output stage, performs an optional immediate range check, and keeps running statistics counters.

---
 rtl/imm_encoder.sv | 160 ++++++++++++++++
 tb/tb_imm_encoder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
//
// Packs a format selector, register indices, function fields and a signed
// 32-bit immediate into an RV32I instruction word. This is the inverse of the
// core's immediate decode path and is used by test/boot infrastructure to
// generate instruction words for memory or a program loader.
//
// A single registered output stage sits behind a valid/ready handshake and
// sustains one word per cycle. Running statistics count accepted requests
// and accepted requests whose immediate did not fit the format.
//
// Optional feature macro: IMM_ENC_RANGE_CHECK_EN
//   defined     -> immediate range check is active, out_err / err_count live
//   not defined -> no check logic, out_err and err_count are tied to zero
//
// Ports:
//   clk        in   1   clock, all state updates on the rising edge
//   reset      in   1   synchronous, active-high reset
//   in_valid   in   1   request present
//   in_ready   out  1   encoder can accept a request this cycle
//   in_fmt     in   2   00 I-type, 01 S-type, 10 B-type, 11 R-type
//   in_opcode  in   7   opcode field
//   in_rd      in   5   destination register (I/R)
//   in_rs1     in   5   source register 1
//   in_rs2     in   5   source register 2 (S/B/R)
//   in_funct3  in   3   funct3 field
//   in_funct7  in   7   funct7 field (R only)
//   in_imm     in   32  signed immediate, not pre-shifted
//   out_valid  out  1   encoded word held in the output register
//   out_ready  in   1   consumer accepts the held word
//   out_instr  out  32  encoded instruction
//   out_err    out  1   immediate out of range for the format
//   enc_count  out  16  accepted requests, wrapping
//   err_count  out  16  accepted requests with error, saturating
// ---------------------------------------------------------------------------
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);

    // Format selector; the I/S/B codes match the core's ImmSrc encoding.
    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_R = 2'b11
    } fmt_t;

    fmt_t        w_fmt;
    logic [31:0] w_instr;
    logic        w_err;
    logic        w_accept;

    logic        r_valid;
    logic [31:0] r_instr;
    logic [15:0] r_enc_count;

    assign w_fmt = fmt_t'(in_fmt);

    // The output register can take a new word when it is empty or when the
    // word it holds leaves this same cycle, giving full 1/cycle throughput.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Field packing. Immediate bits outside each format's field are simply
    // dropped; whether that loses information is the range check's job.
    always_comb begin
        w_instr = '0;
        case (w_fmt)
            FMT_I: w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:0], in_opcode};
            FMT_B: w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            FMT_R: w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            default: w_instr = '0;
        endcase
    end

`ifdef IMM_ENC_RANGE_CHECK_EN
    logic        r_err;
    logic [15:0] r_err_count;

    // A value fits a signed N-bit field exactly when every bit from the
    // field's sign position upward equals the sign. B offsets are 13 bits
    // wide and must be even because bit 0 is never stored.
    always_comb begin
        w_err = 1'b0;
        case (w_fmt)
            FMT_I, FMT_S: w_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            FMT_B:        w_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) ||
                                  in_imm[0];
            default:      w_err = 1'b0;
        endcase
    end

    // Error flag travels with its word; the error counter sticks at all-ones
    // so a saturated value always means "at least this many".
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else if (w_accept) begin
            r_err <= w_err;
            if (w_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign out_err   = r_err;
    assign err_count = r_err_count;
`else
    logic w_unused;

    // Without the check, the high immediate bits never influence anything.
    assign w_err     = 1'b0;
    assign w_unused  = ^{in_imm[31:13], w_err};
    assign out_err   = 1'b0;
    assign err_count = '0;
`endif

    // Output stage plus request counter. A new accept always wins over a
    // consume, so a simultaneous consume/accept leaves the stage full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_instr     <= '0;
            r_enc_count <= '0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_instr     <= w_instr;
            r_enc_count <= r_enc_count + 16'd1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign enc_count = r_enc_count;

endmodule

// File: tb/tb_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_encoder
//
// Self-checking bench for imm_encoder. Expected words come from a reference
// encoder that builds each instruction with masks and shifts, a range model
// using signed integer bounds, and a one-entry output model driven by the
// handshake rules. Random words are also run through an immediate decoder
// to confirm the round trip. Honours IMM_ENC_RANGE_CHECK_EN like the design.
// ---------------------------------------------------------------------------
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    int passCount;
    int checkCount;
    int mEnc;
    int mErr;

    imm_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: place each field at its bit offset arithmetically.
    function automatic logic [31:0] refEncode(input logic [1:0] f, input logic [6:0] op,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] base;
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (f)
            2'd0: return base | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
            2'd1: return base | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20)
                              | ((imm & 32'h1F) << 7);
            2'd2: return base | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                              | (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8)
                              | (((imm >> 11) & 32'h1) << 7);
            default: return base | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
        endcase
    endfunction

    // Reference range check expressed as signed integer bounds.
    function automatic logic refErr(input logic [1:0] f, input logic [31:0] imm);
`ifdef IMM_ENC_RANGE_CHECK_EN
        int s;
        s = $signed(imm);
        case (f)
            2'd0, 2'd1: return (s < -2048) || (s > 2047);
            2'd2:       return (s < -4096) || (s > 4094) || (imm[0] != 1'b0);
            default:    return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // The core's immediate decoder, selected by ImmSrc.
    function automatic logic [31:0] decodeImm(input logic [1:0] src, input logic [31:0] w);
        case (src)
            2'd0:    return {{20{w[31]}}, w[31:20]};
            2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            default: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        endcase
    endfunction

    // Stimulus: load request fields.
    task automatic applyStimulus(input logic [1:0] f, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
        in_fmt    = f;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    // One reset cycle; clears the bench's counter model too.
    task automatic doReset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        mEnc  = 0;
        mErr  = 0;
    endtask

    // Reset state, with a request offered during reset that must be ignored.
    task automatic test_reset();
        reset     = 1'b1;
        out_ready = 1'b0;
        applyStimulus(2'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkCount++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        else passCount++;
        checkCount++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        else passCount++;
        checkCount++;
        if (out_instr !== 32'd0) $display("[TB] FAIL reset_out_instr got %h want 0", out_instr);
        else passCount++;
        checkCount++;
        if (out_err !== 1'b0) $display("[TB] FAIL reset_out_err got %b want 0", out_err);
        else passCount++;
        checkCount++;
        if (enc_count !== 16'd0 || err_count !== 16'd0)
            $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", enc_count, err_count);
        else passCount++;
        in_valid = 1'b0;
        reset    = 1'b0;
        mEnc     = 0;
        mErr     = 0;
    endtask

    // Known instruction words, each accepted then consumed.
    task automatic test_directed();
        logic [1:0]  fv [3];
        logic [31:0] want [3];
        fv   = '{2'd0, 2'd1, 2'd2};
        want = '{32'h00500093, 32'h0021A423, 32'hFE208EE3};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: applyStimulus(2'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h55, 32'd5);
                1: applyStimulus(2'd1, 7'h23, 5'd9, 5'd3, 5'd2, 3'd2, 7'h55, 32'd8);
                default: applyStimulus(2'd2, 7'h63, 5'd9, 5'd1, 5'd2, 3'd0, 7'h55, 32'hFFFFFFFC);
            endcase
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            mEnc++;
            checkCount++;
            if (out_valid !== 1'b1 || out_instr !== want[i] || out_err !== 1'b0)
                $display("[TB] FAIL directed_fmt%0d got v=%b %h e=%b want v=1 %h e=0",
                         fv[i], out_valid, out_instr, out_err, want[i]);
            else passCount++;
            @(posedge clk); #1;
            checkCount++;
            if (out_valid !== 1'b0) $display("[TB] FAIL directed_consume got %b want 0", out_valid);
            else passCount++;
        end
        checkCount++;
        if (enc_count !== 16'(mEnc))
            $display("[TB] FAIL directed_enc_count got %0d want %0d", enc_count, mEnc);
        else passCount++;
    endtask

    // Out-of-range I and B immediates.
    task automatic test_range_errors();
        logic wantErr;
        doReset();
        out_ready = 1'b1;
        applyStimulus(2'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        wantErr = refErr(2'd0, 32'd2048);
        in_valid = 1'b1;
        @(posedge clk); #1;
        mEnc++;
        if (wantErr) mErr++;
        checkCount++;
        if (out_instr[31:20] !== 12'h800 || out_err !== wantErr)
            $display("[TB] FAIL range_i got imm=%h e=%b want 800 e=%b",
                     out_instr[31:20], out_err, wantErr);
        else passCount++;
        applyStimulus(2'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        wantErr = refErr(2'd2, 32'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        mEnc++;
        if (wantErr) mErr++;
        checkCount++;
        if (out_err !== wantErr || out_instr !== refEncode(2'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3))
            $display("[TB] FAIL range_b got %h e=%b want e=%b", out_instr, out_err, wantErr);
        else passCount++;
        checkCount++;
        if (err_count !== 16'(mErr) || enc_count !== 16'(mEnc))
            $display("[TB] FAIL range_counts got %0d/%0d want %0d/%0d",
                     enc_count, err_count, mEnc, mErr);
        else passCount++;
        @(posedge clk); #1;
    endtask

    // Stall, then a 4-deep stream, then reset while a word is held.
    task automatic test_back_to_back();
        logic [31:0] held;
        logic [31:0] want;
        doReset();
        applyStimulus(2'd0, 7'h13, 5'd7, 5'd4, 5'd0, 3'd1, 7'd0, 32'd100);
        held = refEncode(2'd0, 7'h13, 5'd7, 5'd4, 5'd0, 3'd1, 7'd0, 32'd100);
        in_valid = 1'b1;
        @(posedge clk); #1;
        mEnc++;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(2'd3, 7'h33, 5'(c), 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
            @(posedge clk); #1;
            checkCount++;
            if (out_valid !== 1'b1 || out_instr !== held || in_ready !== 1'b0)
                $display("[TB] FAIL stall_cycle%0d got v=%b %h rdy=%b want v=1 %h rdy=0",
                         c, out_valid, out_instr, in_ready, held);
            else passCount++;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'd1, 7'h23, 5'd0, 5'(k + 1), 5'(k + 8), 3'd2, 7'd0, 32'(k * 16 - 20));
            want = refEncode(2'd1, 7'h23, 5'd0, 5'(k + 1), 5'(k + 8), 3'd2, 7'd0, 32'(k * 16 - 20));
            @(posedge clk); #1;
            mEnc++;
            checkCount++;
            if (out_valid !== 1'b1 || out_instr !== want)
                $display("[TB] FAIL stream_word%0d got v=%b %h want v=1 %h", k, out_valid, out_instr, want);
            else passCount++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkCount++;
        if (enc_count !== 16'(mEnc) || mEnc != 5)
            $display("[TB] FAIL stream_enc_count got %0d want 5", enc_count);
        else passCount++;
        reset    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        mEnc = 0;
        mErr = 0;
        checkCount++;
        if (out_valid !== 1'b0 || enc_count !== 16'd0 || err_count !== 16'd0)
            $display("[TB] FAIL midreset got v=%b enc=%0d err=%0d want 0/0/0",
                     out_valid, enc_count, err_count);
        else passCount++;
    endtask

    // Random traffic against the one-entry output model, plus round-trip decode.
    task automatic test_random();
        logic        mFull;
        logic [31:0] mWord;
        logic        mErrBit;
        logic        expReady;
        logic        acc;
        logic [1:0]  f;
        logic [31:0] imm;
        logic [31:0] dec;
        logic        inRange;
        doReset();
        mFull   = 1'b0;
        mWord   = '0;
        mErrBit = 1'b0;
        for (int n = 0; n < 400; n++) begin
            f = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) imm = $urandom;
            else if (f == 2'd2) imm = 32'(($urandom_range(0, 4095) - 2048) * 2);
            else imm = 32'($urandom_range(0, 4095) - 2048);
            applyStimulus(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                          3'($urandom), 7'($urandom), imm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            expReady = !mFull || out_ready;
            checkCount++;
            if (in_ready !== expReady)
                $display("[TB] FAIL rand_in_ready n=%0d got %b want %b", n, in_ready, expReady);
            else passCount++;
            acc = in_valid && expReady;
            @(posedge clk);
            if (acc) begin
                mFull   = 1'b1;
                mWord   = refEncode(f, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, imm);
                mErrBit = refErr(f, imm);
                mEnc    = (mEnc + 1) % 65536;
                if (mErrBit && mErr < 65535) mErr++;
            end else if (mFull && out_ready) begin
                mFull = 1'b0;
            end
            #1;
            checkCount++;
            if (out_valid !== mFull || (mFull && (out_instr !== mWord || out_err !== mErrBit)))
                $display("[TB] FAIL rand_out n=%0d got v=%b %h e=%b want v=%b %h e=%b",
                         n, out_valid, out_instr, out_err, mFull, mWord, mErrBit);
            else passCount++;
            checkCount++;
            if (enc_count !== 16'(mEnc) || err_count !== 16'(mErr))
                $display("[TB] FAIL rand_counts n=%0d got %0d/%0d want %0d/%0d",
                         n, enc_count, err_count, mEnc, mErr);
            else passCount++;
            inRange = (f == 2'd2) ? ($signed(imm) >= -4096 && $signed(imm) <= 4094 && !imm[0])
                                  : ($signed(imm) >= -2048 && $signed(imm) <= 2047);
            if (acc && f != 2'd3 && inRange) begin
                dec = decodeImm(f, out_instr);
                checkCount++;
                if (dec !== imm)
                    $display("[TB] FAIL roundtrip n=%0d fmt=%0d got %h want %h", n, f, dec, imm);
                else passCount++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    // Test sequence and summary.
    initial begin
        passCount  = 0;
        checkCount = 0;
        mEnc       = 0;
        mErr       = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        applyStimulus(2'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(negedge clk);
        test_reset();
        test_directed();
        test_range_errors();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
